// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for a shared serial bus with one
// outstanding split transaction and a watchdog on every tenure.
module bus_arbiter #(
  parameter int NM      = 2,
  parameter int NS      = 3,
  parameter int TIMEOUT = 256,
  parameter int MW      = (NM > 1) ? $clog2(NM) : 1,
  parameter int SW      = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NM-1:0] req,
  input  logic [NM-1:0] done,
  input  logic [NS-1:0] hold_in,
  output logic [NM-1:0] grant,
  output logic [MW-1:0] grant_id,
  output logic [NS-1:0] bus_avail,
  output logic          split_pending,
  output logic          timeout
);

  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WD_MAX  = '1;

  typedef enum logic [1:0] {IDLE, OWN, RESUME} state_t;

  state_t        state_q, state_d;
  logic [NM-1:0] grant_q, grant_d;
  logic [MW-1:0] gid_q, gid_d;
  logic [NS-1:0] avail_q, avail_d;
  logic          split_pending_q, split_pending_d;
  logic          split_ready_q, split_ready_d;
  logic [MW-1:0] split_m_q, split_m_d;
  logic [SW-1:0] split_s_q, split_s_d;
  logic [MW-1:0] rr_last_q, rr_last_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [NS-1:0] hold_q;
  logic          timeout_q, timeout_d;

  logic [NS-1:0] rise, fall;
  logic [NM-1:0] elig;
  logic [MW:0]   pick;
  logic [SW:0]   lo;
  logic [WW-1:0] wdog_inc;
  logic          expire;
  logic          rel;

  function automatic logic [MW:0] rr_pick(
    input logic [NM-1:0] el,
    input logic [MW-1:0] last
  );
    logic [MW:0]   r;
    logic [MW-1:0] ci;
    int            c;
    r = '0;
    for (int k = 1; k <= NM; k++) begin
      c  = (int'(last) + k) % NM;
      ci = MW'(c);
      if (!r[MW] && el[ci]) r = {1'b1, ci};
    end
    return r;
  endfunction

  function automatic logic [SW:0] low_pick(input logic [NS-1:0] v);
    logic [SW:0] r;
    r = '0;
    for (int s = NS - 1; s >= 0; s--)
      if (v[s]) r = {1'b1, SW'(s)};
    return r;
  endfunction

  always_comb begin
    rise = hold_in & ~hold_q;
    fall = hold_q & ~hold_in;
    elig = req;
    if (split_pending_q) elig[split_m_q] = 1'b0;
    pick = rr_pick(elig, rr_last_q);
    lo   = low_pick(rise);
    wdog_inc = (wdog_q == WD_MAX) ? wdog_q : wdog_q + WW'(1);
    expire   = (wdog_q >= WD_LAST);
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    gid_d           = gid_q;
    avail_d         = avail_q;
    split_pending_d = split_pending_q;
    split_ready_d   = split_ready_q;
    split_m_d       = split_m_q;
    split_s_d       = split_s_q;
    rr_last_d       = rr_last_q;
    wdog_d          = wdog_q;
    timeout_d       = 1'b0;
    rel             = 1'b0;

    // slave delay finished: resume becomes possible from any state
    if (split_pending_q && fall[split_s_q]) split_ready_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (split_ready_q) begin
          state_d = RESUME;
          grant_d = NM'(1) << split_m_q;
          gid_d   = split_m_q;
          avail_d = NS'(1) << split_s_q;
        end else if (pick[MW]) begin
          state_d   = OWN;
          grant_d   = NM'(1) << pick[MW-1:0];
          gid_d     = pick[MW-1:0];
          rr_last_d = pick[MW-1:0];
          avail_d   = '0;
        end
      end
      OWN: begin
        wdog_d = wdog_inc;
        if (done[gid_q]) begin
          rel = 1'b1;
        end else if (lo[SW] && !split_pending_q) begin
          split_pending_d = 1'b1;
          split_m_d       = gid_q;
          split_s_d       = lo[SW-1:0];
          rel             = 1'b1;
        end else if (lo[SW]) begin
          avail_d = avail_q | rise;
        end else if (expire) begin
          rel       = 1'b1;
          timeout_d = 1'b1;
        end
      end
      RESUME: begin
        wdog_d = wdog_inc;
        if (done[split_m_q] || expire) begin
          rel             = 1'b1;
          timeout_d       = !done[split_m_q];
          split_pending_d = 1'b0;
          split_ready_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rel) begin
      state_d = IDLE;
      grant_d = '0;
      gid_d   = '0;
      avail_d = '0;
      wdog_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      gid_q           <= '0;
      avail_q         <= '0;
      split_pending_q <= 1'b0;
      split_ready_q   <= 1'b0;
      split_m_q       <= '0;
      split_s_q       <= '0;
      rr_last_q       <= MW'(NM - 1);
      wdog_q          <= '0;
      hold_q          <= '0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      gid_q           <= gid_d;
      avail_q         <= avail_d;
      split_pending_q <= split_pending_d;
      split_ready_q   <= split_ready_d;
      split_m_q       <= split_m_d;
      split_s_q       <= split_s_d;
      rr_last_q       <= rr_last_d;
      wdog_q          <= wdog_d;
      hold_q          <= hold_in;
      timeout_q       <= timeout_d;
    end
  end

  assign grant         = grant_q;
  assign grant_id      = gid_q;
  assign bus_avail     = avail_q;
  assign split_pending = split_pending_q;
  assign timeout       = timeout_q;

endmodule
